// File: rtl/selfadd_feed_ctrl_pkg.sv
// Shared definitions for the self-accumulating register unit feeders:
// default geometry, issue spacing and the issue-controller FSM states.
package selfadd_feed_ctrl_pkg;

  // Lane width of the accumulator operands.
  localparam int DEF_DW = 16;

  // Width of the per-group beat counter.
  localparam int DEF_CNT_W = 8;

  // Add latency of the accumulator; also the minimum issue spacing.
  localparam int DEF_ISSUE_GAP = 3;

  // Default input buffer depth.
  localparam int DEF_FIFO_DEPTH = 8;

  // Issue controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } feed_state_t;

endpackage

// File: rtl/selfadd_sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty.
// rd_data shows the head entry one cycle after that entry was written or
// became the head, so a consumer that registers its pop decision (decides
// in one cycle, pops in the next) always sees valid head data.
module selfadd_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full_reg;
  logic          empty_reg;
  logic [W-1:0]  rd_data_reg;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full_reg;
  assign pop_ok  = pop && !empty_reg;

  // Read address looks one entry ahead on a pop so the next head is fetched.
  assign rd_addr    = pop_ok ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;
  assign count_next = count_reg + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_L);
      empty_reg <= (count_next == '0);
    end
  end

  assign rd_data = rd_data_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/selfadd_feed_ctrl.sv
// Issue controller in front of the 2x16b self-accumulating register unit.
// Buffers (a,b,last) beats, issues them with at least ISSUE_GAP cycles of
// spacing so the accumulator feedback has settled, flags the first beat of
// every group with acc_usr_rst and parks each group's final sum in a
// ready/valid output slot.
module selfadd_feed_ctrl
  import selfadd_feed_ctrl_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ISSUE_GAP  = DEF_ISSUE_GAP,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data_a,
  input  logic [DW-1:0]    in_data_b,
  input  logic             in_last,
  output logic             acc_data_v,
  output logic [DW-1:0]    acc_data_a,
  output logic [DW-1:0]    acc_data_b,
  output logic             acc_usr_rst,
  input  logic             acc_res_v,
  input  logic [DW-1:0]    acc_res_a,
  input  logic [DW-1:0]    acc_res_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_a,
  output logic [DW-1:0]    res_b,
  output logic [CNT_W-1:0] res_cnt
);

  localparam int FW    = 2 * DW + 1;
  localparam int GAP_W = $clog2(ISSUE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

  feed_state_t      state_reg;
  feed_state_t      state_next;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [CNT_W-1:0] out_cnt_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic             first_reg;
  logic             res_valid_reg;
  logic [DW-1:0]    res_a_reg;
  logic [DW-1:0]    res_b_reg;
  logic [CNT_W-1:0] res_cnt_reg;

  logic [FW-1:0]    fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [DW-1:0]    head_a;
  logic [DW-1:0]    head_b;
  logic             head_last;
  logic             slot_free;
  logic             gap_done;
  logic             res_dec;
  logic             capture;

  selfadd_sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data ({in_last, in_data_b, in_data_a}),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign head_a    = fifo_rd[DW-1:0];
  assign head_b    = fifo_rd[2*DW-1:DW];
  assign head_last = fifo_rd[2*DW];

  // The slot can take a new group if it is empty or being drained this cycle.
  assign slot_free = !res_valid_reg || res_ready;
  assign gap_done  = (gap_cnt_reg <= GAP_W'(1));
  // Result pulses never take the outstanding count below zero, so pulses
  // left over from a group discarded by reset fall on the floor.
  assign res_dec   = acc_res_v && (out_cnt_reg != '0);
  assign capture   = (state_reg == DRAIN) && acc_res_v && (out_cnt_reg == CNT_W'(1));

  // Next-state and issue-side outputs.
  always_comb begin
    state_next  = state_reg;
    fifo_pop    = 1'b0;
    acc_data_v  = 1'b0;
    acc_usr_rst = 1'b0;
    acc_data_a  = '0;
    acc_data_b  = '0;
    case (state_reg)
      IDLE: begin
        // A group may only start once its result has somewhere to land.
        if (!fifo_empty && (!first_reg || slot_free)) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        fifo_pop    = 1'b1;
        acc_data_v  = 1'b1;
        acc_usr_rst = first_reg;
        acc_data_a  = head_a;
        acc_data_b  = head_b;
        state_next  = head_last ? DRAIN : GAP;
      end
      GAP: begin
        if (gap_done && !fifo_empty) begin
          state_next = ISSUE;
        end
      end
      DRAIN: begin
        if (capture) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Spacing counter: loaded on issue, counts down through GAP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_cnt_reg <= '0;
    end else if (acc_data_v) begin
      gap_cnt_reg <= GAP_LOAD;
    end else if (gap_cnt_reg != '0) begin
      gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
    end
  end

  // Beats issued whose result has not come back yet.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_cnt_reg <= '0;
    end else begin
      case ({acc_data_v, res_dec})
        2'b10:   out_cnt_reg <= out_cnt_reg + CNT_W'(1);
        2'b01:   out_cnt_reg <= out_cnt_reg - CNT_W'(1);
        default: out_cnt_reg <= out_cnt_reg;
      endcase
    end
  end

  // Beats in the current group, saturating, and the first-beat flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt_reg <= '0;
      first_reg    <= 1'b1;
    end else if (capture) begin
      beat_cnt_reg <= '0;
      first_reg    <= 1'b1;
    end else if (acc_data_v) begin
      first_reg <= 1'b0;
      if (!(&beat_cnt_reg)) begin
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Output slot: capture the final sum, hold it until accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid_reg <= 1'b0;
      res_a_reg     <= '0;
      res_b_reg     <= '0;
      res_cnt_reg   <= '0;
    end else if (capture) begin
      res_valid_reg <= 1'b1;
      res_a_reg     <= acc_res_a;
      res_b_reg     <= acc_res_b;
      res_cnt_reg   <= beat_cnt_reg;
    end else if (res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign res_valid = res_valid_reg;
  assign res_a     = res_a_reg;
  assign res_b     = res_b_reg;
  assign res_cnt   = res_cnt_reg;

endmodule

// File: tb/tb_selfadd_feed_ctrl.sv
// Directed bench for selfadd_feed_ctrl with a behavioural 3-cycle
// self-accumulating unit attached to the issue side.
module tb_selfadd_feed_ctrl;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data_a = '0;
  logic [DW-1:0] in_data_b = '0;
  logic          in_last = 1'b0;
  logic          acc_data_v;
  logic [DW-1:0] acc_data_a;
  logic [DW-1:0] acc_data_b;
  logic          acc_usr_rst;
  logic          acc_res_v = 1'b0;
  logic [DW-1:0] acc_res_a = '0;
  logic [DW-1:0] acc_res_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_a;
  logic [DW-1:0] res_b;
  logic [CW-1:0] res_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int push_cnt = 0;
  int last_push_cyc = 0;

  int            iss_cyc_q[$];
  logic [DW-1:0] iss_a_q[$];
  logic [DW-1:0] iss_b_q[$];
  logic          iss_rst_q[$];
  int            res_cyc_q[$];
  logic [DW-1:0] res_a_q[$];
  logic [DW-1:0] res_b_q[$];
  logic [CW-1:0] res_cnt_q[$];

  selfadd_feed_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data_a   (in_data_a),
    .in_data_b   (in_data_b),
    .in_last     (in_last),
    .acc_data_v  (acc_data_v),
    .acc_data_a  (acc_data_a),
    .acc_data_b  (acc_data_b),
    .acc_usr_rst (acc_usr_rst),
    .acc_res_v   (acc_res_v),
    .acc_res_a   (acc_res_a),
    .acc_res_b   (acc_res_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_a       (res_a),
    .res_b       (res_b),
    .res_cnt     (res_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Accumulator model (3-cycle latency) and transaction monitor.
  initial begin
    logic          pv [3];
    logic [DW-1:0] pa [3];
    logic [DW-1:0] pb [3];
    logic [DW-1:0] sum_a;
    logic [DW-1:0] sum_b;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; pa[i] = '0; pb[i] = '0;
    end
    sum_a = '0;
    sum_b = '0;
    forever begin
      @(negedge clk);
      #1;
      acc_res_v = pv[2];
      acc_res_a = pa[2];
      acc_res_b = pb[2];
      for (int i = 2; i > 0; i--) begin
        pv[i] = pv[i-1]; pa[i] = pa[i-1]; pb[i] = pb[i-1];
      end
      pv[0] = 1'b0;
      if (acc_data_v) begin
        if (acc_usr_rst) begin
          sum_a = acc_data_a;
          sum_b = acc_data_b;
        end else begin
          sum_a = sum_a + acc_data_a;
          sum_b = sum_b + acc_data_b;
        end
        pv[0] = 1'b1; pa[0] = sum_a; pb[0] = sum_b;
        iss_cyc_q.push_back(cyc);
        iss_a_q.push_back(acc_data_a);
        iss_b_q.push_back(acc_data_b);
        iss_rst_q.push_back(acc_usr_rst);
        $display("cyc %0d issue a=%0d b=%0d usr_rst=%0b", cyc, acc_data_a, acc_data_b, acc_usr_rst);
      end
      if (res_valid && res_ready) begin
        res_cyc_q.push_back(cyc);
        res_a_q.push_back(res_a);
        res_b_q.push_back(res_b);
        res_cnt_q.push_back(res_cnt);
        $display("cyc %0d result a=%0d b=%0d cnt=%0d", cyc, res_a, res_b, res_cnt);
      end
      if (in_valid && in_ready) push_cnt++;
    end
  end

  task automatic clear_logs();
    iss_cyc_q.delete(); iss_a_q.delete(); iss_b_q.delete(); iss_rst_q.delete();
    res_cyc_q.delete(); res_a_q.delete(); res_b_q.delete(); res_cnt_q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
    int w = 0;
    in_valid  = 1'b1;
    in_data_a = a;
    in_data_b = b;
    in_last   = last;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("push_timeout", 32'(in_ready), 32'd1);
    last_push_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, input string tag);
    int w = 0;
    while (res_a_q.size() < n && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (res_a_q.size() < n) chk(tag, 32'(res_a_q.size()), 32'(n));
  endtask

  task automatic chk_res(input int i, input string tag, input int ea, input int eb, input int ec);
    if (res_a_q.size() > i) begin
      chk({tag, "_a"}, 32'(res_a_q[i]), 32'(ea));
      chk({tag, "_b"}, 32'(res_b_q[i]), 32'(eb));
      chk({tag, "_cnt"}, 32'(res_cnt_q[i]), 32'(ec));
    end else begin
      chk({tag, "_missing"}, 32'(res_a_q.size()), 32'(i + 1));
    end
  endtask

  initial begin
    int w;
    int rr_cyc;

    // ---------------- reset release ----------------
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_acc_data_v", 32'(acc_data_v), 32'd0);
    chk("rst_acc_usr_rst", 32'(acc_usr_rst), 32'd0);
    chk("rst_acc_data_a", 32'(acc_data_a), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_a", 32'(res_a), 32'd0);
    chk("rst_res_b", 32'(res_b), 32'd0);
    chk("rst_res_cnt", 32'(res_cnt), 32'd0);

    // ---------------- 3-beat group ----------------
    clear_logs();
    res_ready = 1'b1;
    push(16'd1, 16'd2, 1'b0);
    push(16'd3, 16'd4, 1'b0);
    push(16'd5, 16'd6, 1'b1);
    wait_res(1, "g3_timeout");
    repeat (10) @(negedge clk);
    chk("g3_issues", 32'(iss_cyc_q.size()), 32'd3);
    if (iss_cyc_q.size() >= 3) begin
      chk("g3_gap1", 32'(iss_cyc_q[1] - iss_cyc_q[0]), 32'd3);
      chk("g3_gap2", 32'(iss_cyc_q[2] - iss_cyc_q[0]), 32'd6);
      chk("g3_rst0", 32'(iss_rst_q[0]), 32'd1);
      chk("g3_rst1", 32'(iss_rst_q[1]), 32'd0);
      chk("g3_rst2", 32'(iss_rst_q[2]), 32'd0);
    end
    chk_res(0, "g3", 9, 12, 3);
    chk("g3_one_result", 32'(res_a_q.size()), 32'd1);

    // ---------------- single-beat groups + latency ----------------
    clear_logs();
    for (int k = 1; k <= 4; k++) begin
      push(16'(k), 16'(2 * k), 1'b1);
      if (k == 1) rr_cyc = last_push_cyc;
    end
    wait_res(4, "single_timeout");
    if (iss_cyc_q.size() >= 1 && res_cyc_q.size() >= 1) begin
      chk("single_issue_lat", 32'(iss_cyc_q[0] - rr_cyc), 32'd2);
      chk("single_res_lat", 32'(res_cyc_q[0] - iss_cyc_q[0]), 32'd4);
    end
    for (int k = 1; k <= 4; k++) begin
      chk_res(k - 1, $sformatf("single%0d", k), k, 2 * k, 1);
      if (iss_rst_q.size() >= k) chk($sformatf("single%0d_usr_rst", k), 32'(iss_rst_q[k-1]), 32'd1);
    end

    // ---------------- output backpressure ----------------
    clear_logs();
    res_ready = 1'b0;
    push(16'd10, 16'd1, 1'b0);
    push(16'd20, 16'd2, 1'b1);
    push(16'd100, 16'd5, 1'b1);
    w = 0;
    while (!res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    repeat (10) @(negedge clk);
    chk("bp_no_issue", 32'(iss_cyc_q.size()), 32'd2);
    chk("bp_hold_valid", 32'(res_valid), 32'd1);
    chk("bp_hold_a", 32'(res_a), 32'd30);
    chk("bp_hold_b", 32'(res_b), 32'd3);
    chk("bp_hold_cnt", 32'(res_cnt), 32'd2);
    res_ready = 1'b1;
    rr_cyc = cyc;
    wait_res(2, "bp_timeout");
    if (iss_cyc_q.size() >= 3) chk("bp_issue_next", 32'(iss_cyc_q[2] - rr_cyc), 32'd1);
    else chk("bp_issue_missing", 32'(iss_cyc_q.size()), 32'd3);
    chk_res(0, "bp_g1", 30, 3, 2);
    chk_res(1, "bp_g2", 100, 5, 1);

    // ---------------- FIFO full ----------------
    repeat (5) @(negedge clk);
    clear_logs();
    res_ready = 1'b0;
    push(16'd1, 16'd1, 1'b1);
    w = 0;
    while (!res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    push_cnt = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) push(16'(i + 1), 16'(3 * (i + 1)), (i == 9));
      end
      begin
        int wf = 0;
        while (wf < 50) begin
          @(negedge clk);
          #2;
          if (!in_ready) break;
          wf++;
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_after", 32'(push_cnt), 32'd8);
        repeat (5) @(negedge clk);
        chk("full_stalled", 32'(iss_a_q.size()), 32'd1);
        chk("full_hold", 32'(in_ready), 32'd0);
        res_ready = 1'b1;
      end
    join
    wait_res(2, "full_timeout");
    chk_res(0, "full_g0", 1, 1, 1);
    chk_res(1, "full_g1", 55, 165, 10);
    chk("full_issue_count", 32'(iss_a_q.size()), 32'd11);
    for (int i = 0; i < 10; i++) begin
      if (iss_a_q.size() > i + 1) begin
        chk($sformatf("full_beat%0d_a", i), 32'(iss_a_q[i+1]), 32'(i + 1));
        chk($sformatf("full_beat%0d_b", i), 32'(iss_b_q[i+1]), 32'(3 * (i + 1)));
      end
    end

    // ---------------- mid-group reset ----------------
    repeat (5) @(negedge clk);
    clear_logs();
    push(16'd50, 16'd60, 1'b0);
    push(16'd70, 16'd80, 1'b1);
    w = 0;
    while (iss_cyc_q.size() < 2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_res_valid", 32'(res_valid), 32'd0);
    chk("mr_res_a", 32'(res_a), 32'd0);
    repeat (6) @(negedge clk);
    chk("mr_no_stale", 32'(res_a_q.size()), 32'd0);
    chk("mr_valid_quiet", 32'(res_valid), 32'd0);
    push(16'd7, 16'd8, 1'b1);
    wait_res(1, "mr_timeout");
    repeat (8) @(negedge clk);
    chk_res(0, "mr", 7, 8, 1);
    chk("mr_one_result", 32'(res_a_q.size()), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
